// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD controller.
//   - lcd_state_t : controller state encoding
//   - t_en/t_cmd/t_long/t_pwr : timing constants in clk cycles for a given CLK_HZ
//   - init_ent    : power-up command table (nibble-only flag + byte)
//   - is_clr_home : detects clear-display / return-home commands (long execution)
package lcd_pkg;

    // Largest supported clock; T_PWR at this rate must fit the timer.
    localparam int unsigned CLK_HZ_MAX = 1_000_000_000;
    localparam int          TMR_W      = 24;   // 15000 * 1000 = 15e6 < 2^24

    typedef logic [TMR_W-1:0] tmr_t;

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, IDLE, SETUP, EN_HI, GAP, WAIT
    } lcd_state_t;

    typedef struct packed {
        logic       nib_only;   // single high-nibble write (4-bit wake-up)
        logic [7:0] data;
    } init_ent_t;

    function automatic tmr_t t_en(input int unsigned clk_hz);
        return tmr_t'(clk_hz / 1_000_000);
    endfunction

    function automatic tmr_t t_cmd(input int unsigned clk_hz);
        return tmr_t'(40 * (clk_hz / 1_000_000));
    endfunction

    function automatic tmr_t t_long(input int unsigned clk_hz);
        return tmr_t'(1640 * (clk_hz / 1_000_000));
    endfunction

    function automatic tmr_t t_pwr(input int unsigned clk_hz);
        return tmr_t'(15000 * (clk_hz / 1_000_000));
    endfunction

    // Index of the last init entry: 4 nibble wake-ups precede the commands in 4-bit mode.
    function automatic logic [2:0] init_last(input logic bus4);
        return bus4 ? 3'd7 : 3'd3;
    endfunction

    function automatic init_ent_t init_ent(input logic bus4, input logic two_line,
                                           input logic [2:0] idx);
        init_ent_t  e;
        logic [7:0] fset;
        fset       = 8'h30 | (bus4 ? 8'h00 : 8'h10) | {4'b0, two_line, 3'b0};
        e.nib_only = 1'b0;
        e.data     = 8'h00;
        if (bus4 && !idx[2]) begin
            e.nib_only = 1'b1;
            e.data     = (idx[1:0] == 2'd3) ? 8'h20 : 8'h30;
        end else begin
            case (idx[1:0])
                2'd0:    e.data = fset;
                2'd1:    e.data = 8'h0C;
                2'd2:    e.data = 8'h01;
                default: e.data = 8'h06;
            endcase
        end
        return e;
    endfunction

    function automatic logic is_clr_home(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data[7:1] == 7'b0000001);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter used for every timed state of the LCD controller.
//   clk, rstn : clock, async active-low reset
//   start     : load 'load' into the counter (overrides counting)
//   load      : cycles to count
//   done      : high during the last counted cycle (one-cycle pulse)
//   idle      : counter is at zero
module lcd_timer
    import lcd_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         done,
    output logic         idle
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)            cnt <= '0;
        else if (start)       cnt <= load;
        else if (cnt != '0)   cnt <= cnt - W'(1);
    end

    // Loaded with N on the entry edge, the owning state sees done in its N-th cycle
    // and leaves on the following edge, so it lasts exactly N cycles.
    assign done = (cnt == W'(1));
    assign idle = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD write controller with power-up initialisation.
//   clk, rstn          : clock, async active-low reset
//   req_valid/req_ready: request handshake; req_rs (0 cmd, 1 data), req_data byte
//   init_done          : power-up sequence finished (sticky until reset)
//   busy               : inverse of req_ready
//   LCD_ON/EN/RS/RW    : panel control pins; LCD_DATA panel bus (4-bit on [7:4])
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter bit          BUS4     = 1'b0,
    parameter bit          TWO_LINE = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       busy,
    output logic       LCD_ON,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam tmr_t T_EN   = t_en(CLK_HZ);
    localparam tmr_t T_CMD  = t_cmd(CLK_HZ);
    localparam tmr_t T_LONG = t_long(CLK_HZ);
    localparam tmr_t T_PWR  = t_pwr(CLK_HZ);

    lcd_state_t state, state_d;
    logic       cur_rs, cur_rs_d;
    logic [7:0] cur_data, cur_data_d;
    logic       nib_only, nib_only_d;
    logic       lo_nib, lo_nib_d;          // low nibble currently on the bus
    logic [2:0] init_idx, init_idx_d;
    logic       init_done_d;
    logic       tmr_start, tmr_done, tmr_idle;
    tmr_t       tmr_load, wait_len;
    init_ent_t  ent;
    logic       en_d;
    logic [7:0] data_d;

    lcd_timer #(.W(TMR_W)) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .start (tmr_start),
        .load  (tmr_load),
        .done  (tmr_done),
        .idle  (tmr_idle)
    );

    assign req_ready = (state == IDLE) && init_done;
    assign busy      = ~req_ready;
    assign LCD_RW    = 1'b0;
    assign LCD_ON    = rstn;

    always_comb begin
        state_d     = state;
        cur_rs_d    = cur_rs;
        cur_data_d  = cur_data;
        nib_only_d  = nib_only;
        lo_nib_d    = lo_nib;
        init_idx_d  = init_idx;
        init_done_d = init_done;
        tmr_start   = 1'b0;
        tmr_load    = T_EN;
        ent         = init_ent(BUS4, TWO_LINE, init_idx);
        wait_len    = (nib_only || is_clr_home(cur_rs, cur_data)) ? T_LONG : T_CMD;

        case (state)
            PWR_WAIT: begin
                // The kick-off cycle counts toward the power-up wait.
                if (tmr_idle) begin
                    tmr_start = 1'b1;
                    tmr_load  = T_PWR - tmr_t'(1);
                end else if (tmr_done) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                cur_rs_d   = 1'b0;
                cur_data_d = ent.data;
                nib_only_d = ent.nib_only;
                lo_nib_d   = 1'b0;
                state_d    = SETUP;
            end
            IDLE: begin
                if (req_valid && init_done) begin
                    cur_rs_d   = req_rs;
                    cur_data_d = req_data;
                    nib_only_d = 1'b0;
                    lo_nib_d   = 1'b0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                state_d   = EN_HI;
                tmr_start = 1'b1;
                tmr_load  = T_EN;
            end
            EN_HI: begin
                if (tmr_done) begin
                    tmr_start = 1'b1;
                    if (BUS4 && !nib_only && !lo_nib) begin
                        state_d  = GAP;
                        lo_nib_d = 1'b1;
                        tmr_load = T_EN;
                    end else begin
                        state_d  = WAIT;
                        tmr_load = wait_len;
                    end
                end
            end
            GAP: begin
                if (tmr_done) begin
                    state_d   = EN_HI;
                    tmr_start = 1'b1;
                    tmr_load  = T_EN;
                end
            end
            WAIT: begin
                if (tmr_done) begin
                    if (init_done) begin
                        state_d = IDLE;
                    end else if (init_idx == init_last(BUS4)) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        init_idx_d = init_idx + 3'd1;
                        state_d    = INIT;
                    end
                end
            end
            default: state_d = PWR_WAIT;
        endcase

        // Pins follow the next state so they are registered yet aligned with it;
        // the bus only moves on SETUP/GAP entry, both of which have EN low.
        en_d   = (state_d == EN_HI);
        data_d = BUS4 ? {(lo_nib_d ? cur_data_d[3:0] : cur_data_d[7:4]), 4'h0} : cur_data_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= PWR_WAIT;
            cur_rs    <= 1'b0;
            cur_data  <= 8'h00;
            nib_only  <= 1'b0;
            lo_nib    <= 1'b0;
            init_idx  <= 3'd0;
            init_done <= 1'b0;
            LCD_EN    <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_DATA  <= 8'h00;
        end else begin
            state     <= state_d;
            cur_rs    <= cur_rs_d;
            cur_data  <= cur_data_d;
            nib_only  <= nib_only_d;
            lo_nib    <= lo_nib_d;
            init_idx  <= init_idx_d;
            init_done <= init_done_d;
            LCD_EN    <= en_d;
            LCD_RS    <= cur_rs_d;
            LCD_DATA  <= data_d;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench: an 8-bit and a 4-bit controller at 1 MHz side by side.
module tb_lcd_ctrl;
    import lcd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // 8-bit DUT
    logic rstn8, valid8, ready8, rs8, idone8, busy8, on8, en8, lrs8, rw8;
    logic [7:0] data8, ldata8;
    lcd_ctrl #(.CLK_HZ(1_000_000), .BUS4(1'b0), .TWO_LINE(1'b1)) u_dut8 (
        .clk(clk), .rstn(rstn8), .req_valid(valid8), .req_ready(ready8), .req_rs(rs8),
        .req_data(data8), .init_done(idone8), .busy(busy8), .LCD_ON(on8), .LCD_EN(en8),
        .LCD_RS(lrs8), .LCD_RW(rw8), .LCD_DATA(ldata8));

    // 4-bit DUT
    logic rstn4, valid4, ready4, rs4, idone4, busy4, on4, en4, lrs4, rw4;
    logic [7:0] data4, ldata4;
    lcd_ctrl #(.CLK_HZ(1_000_000), .BUS4(1'b1), .TWO_LINE(1'b1)) u_dut4 (
        .clk(clk), .rstn(rstn4), .req_valid(valid4), .req_ready(ready4), .req_rs(rs4),
        .req_data(data4), .init_done(idone4), .busy(busy4), .LCD_ON(on4), .LCD_EN(en4),
        .LCD_RS(lrs4), .LCD_RW(rw4), .LCD_DATA(ldata4));

    // Pin monitors: {RS,DATA} at each EN rise, rise cycle, EN width, stability errors.
    logic [8:0] rise8[$], rise4[$];
    int rcyc8[$], rcyc4[$], wid8[$], wid4[$];
    logic en8_q = 0, en4_q = 0, idn8_q = 0, idn4_q = 0;
    logic [8:0] hold8 = 0, hold4 = 0, prev8 = 0, prev4 = 0;
    int wcnt8 = 0, wcnt4 = 0, stab8 = 0, stab4 = 0, idcyc8 = 0, idcyc4 = 0;

    always @(negedge clk) begin
        en8_q  <= en8;
        idn8_q <= idone8;
        prev8  <= {lrs8, ldata8};
        if (idone8 && !idn8_q) idcyc8 <= cyc;
        if (en8 && !en8_q) begin
            rise8.push_back({lrs8, ldata8});
            rcyc8.push_back(cyc);
            hold8 <= {lrs8, ldata8};
            wcnt8 <= 1;
            if ({lrs8, ldata8} != prev8) stab8 <= stab8 + 1;
        end else if (en8) begin
            wcnt8 <= wcnt8 + 1;
            if ({lrs8, ldata8} != hold8) stab8 <= stab8 + 1;
        end else if (en8_q) begin
            wid8.push_back(wcnt8);
        end
    end

    always @(negedge clk) begin
        en4_q  <= en4;
        idn4_q <= idone4;
        prev4  <= {lrs4, ldata4};
        if (idone4 && !idn4_q) idcyc4 <= cyc;
        if (en4 && !en4_q) begin
            rise4.push_back({lrs4, ldata4});
            rcyc4.push_back(cyc);
            hold4 <= {lrs4, ldata4};
            wcnt4 <= 1;
            if ({lrs4, ldata4} != prev4) stab4 <= stab4 + 1;
        end else if (en4) begin
            wcnt4 <= wcnt4 + 1;
            if ({lrs4, ldata4} != hold4) stab4 <= stab4 + 1;
        end else if (en4_q) begin
            wid4.push_back(wcnt4);
        end
    end

    // Single request; lat = cycles from accept edge to req_ready high (-1 on timeout).
    task automatic req8(input logic rs, input logic [7:0] d, output int lat);
        int acc;
        valid8 = 1'b1; rs8 = rs; data8 = d;
        tick;
        acc = cyc; valid8 = 1'b0;
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (ready8) begin lat = cyc - acc; break; end
            tick;
        end
    endtask

    task automatic req4(input logic rs, input logic [7:0] d, output int lat);
        int acc;
        valid4 = 1'b1; rs4 = rs; data4 = d;
        tick;
        acc = cyc; valid4 = 1'b0;
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (ready4) begin lat = cyc - acc; break; end
            tick;
        end
    endtask

    localparam logic [7:0] EXP_INIT8 [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    initial begin
        int rel, lat, n0, n4;
        rstn8 = 0; valid8 = 0; rs8 = 0; data8 = 0;
        rstn4 = 0; valid4 = 0; rs4 = 0; data4 = 0;
        repeat (3) tick;

        chk("rst_pins8", {en8, lrs8, ldata8, on8}, 0);
        chk("rst_hs8", {ready8, busy8, idone8}, 3'b010);
        chk("rst_pins4", {en4, lrs4, ldata4, on4, ready4, busy4, idone4}, 4'b0010);
        chk("rw8", rw8, 0);

        rstn8 = 1; rstn4 = 1; rel = cyc;
        #1;
        chk("on_after_rst", {on8, on4}, 2'b11);
        for (int i = 0; i < 30000 && !(idone8 && idone4); i++) tick;
        chk("init_done8", idone8, 1);
        chk("init_done4", idone4, 1);
        chk("ready_busy4", {ready4, busy4}, 2'b10);

        // 8-bit init: power wait, command bytes, inter-command spacing
        chk("init_cnt8", rise8.size(), 4);
        if (rise8.size() >= 4) begin
            chk("pwr_wait8", (rcyc8[0] - rel) >= 15000, 1);
            for (int k = 0; k < 4; k++) chk("init_cmd8", rise8[k], {1'b0, EXP_INIT8[k]});
            // EN + 40-cycle wait + INIT + SETUP
            chk("gap_0C_01", rcyc8[2] - rcyc8[1], 43);
            // EN + 1640-cycle wait + INIT + SETUP
            chk("gap_01_06", rcyc8[3] - rcyc8[2], 1643);
            chk("done_after_06", idcyc8 - rcyc8[3], 41);
        end

        // 4-bit init: 4 wake-up nibbles, then 4 commands of two nibbles each
        chk("init_cnt4", rise4.size(), 12);
        if (rise4.size() >= 12) begin
            chk("wake0_4", rise4[0], {1'b0, 8'h30});
            chk("wake3_4", rise4[3], {1'b0, 8'h20});
            chk("wake_gap4", rcyc4[1] - rcyc4[0], 1643);
            chk("clr_hi4", rise4[8], {1'b0, 8'h00});
            chk("clr_lo4", rise4[9], {1'b0, 8'h10});
        end

        // Data write, 8-bit
        chk("ready8", ready8, 1);
        n0 = rise8.size();
        req8(1'b1, 8'h41, lat);
        chk("lat_41", lat, 42);
        chk("cnt_41", rise8.size() - n0, 1);
        if (rise8.size() > n0) chk("pulse_41", rise8[n0], {1'b1, 8'h41});
        if (wid8.size() > n0)  chk("width_41", wid8[n0], 1);

        // Back-to-back: valid held high; data changes while busy
        n0 = rise8.size();
        valid8 = 1; rs8 = 1; data8 = 8'h42;
        tick;
        chk("busy_after_acc", {ready8, busy8}, 2'b01);
        data8 = 8'h43;
        for (int i = 0; i < 200 && !ready8; i++) tick;
        tick;
        valid8 = 0;
        chk("b2b_second_acc", ready8, 0);
        for (int i = 0; i < 200 && !ready8; i++) tick;
        chk("b2b_ready", ready8, 1);
        chk("b2b_cnt", rise8.size() - n0, 2);
        if (rise8.size() >= n0 + 2) begin
            chk("b2b_first", rise8[n0], {1'b1, 8'h42});
            chk("b2b_second", rise8[n0 + 1], {1'b1, 8'h43});
            chk("b2b_spacing", rcyc8[n0 + 1] - rcyc8[n0], 43);
        end

        // Clear command, 4-bit
        n4 = rise4.size();
        req4(1'b0, 8'h01, lat);
        chk("lat_clr4", lat, 1644);
        chk("cnt_clr4", rise4.size() - n4, 2);
        if (rise4.size() >= n4 + 2) begin
            chk("clr4_hi", rise4[n4], {1'b0, 8'h00});
            chk("clr4_lo", rise4[n4 + 1], {1'b0, 8'h10});
            chk("clr4_nib_gap", rcyc4[n4 + 1] - rcyc4[n4], 2);
        end

        // Reset during EN_HI of a data write
        valid8 = 1; rs8 = 1; data8 = 8'h44;
        tick;
        valid8 = 0;
        for (int i = 0; i < 10 && !en8; i++) tick;
        chk("mid_en_seen", en8, 1);
        rstn8 = 0;
        #1;
        chk("mid_en_async", en8, 0);
        chk("mid_on", on8, 0);
        repeat (3) tick;
        chk("mid_rst_hs", {ready8, busy8, idone8, lrs8, ldata8}, 11'b010_0_00000000);
        rstn8 = 1; rel = cyc; n0 = rise8.size();
        for (int i = 0; i < 20000 && !idone8; i++) tick;
        chk("reinit_done", idone8, 1);
        chk("reinit_cnt", rise8.size() - n0, 4);
        if (rise8.size() >= n0 + 4) begin
            chk("reinit_pwr", (rcyc8[n0] - rel) >= 15000, 1);
            for (int k = 0; k < 4; k++) chk("reinit_cmd", rise8[n0 + k], {1'b0, EXP_INIT8[k]});
        end

        chk("stab8", stab8, 0);
        chk("stab4", stab4, 0);

        // Timing constants at 50 MHz and clear/home detection
        chk("t_en_50M", 32'(t_en(50_000_000)), 50);
        chk("t_cmd_50M", 32'(t_cmd(50_000_000)), 2000);
        chk("t_long_1M", 32'(t_long(1_000_000)), 1640);
        chk("t_pwr_1M", 32'(t_pwr(1_000_000)), 15000);
        chk("clrhome_02", is_clr_home(1'b0, 8'h02), 1);
        chk("clrhome_03", is_clr_home(1'b0, 8'h03), 1);
        chk("clrhome_rs1", is_clr_home(1'b1, 8'h01), 0);
        chk("clrhome_04", is_clr_home(1'b0, 8'h04), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
